// File: rtl/floatmul_rr_arbiter.sv
// Round-robin front end sharing one floatmul between N_REQ requesters; a tag FIFO returns each result to its issuer.
// Grant->issue 1 cycle (one pair per 2 cycles max); grants stop at TAG_DEPTH outstanding, a blocked result stalls all later ones.

module floatmul_rr_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A pop frees the slot a same-cycle push needs, so push is legal when full if popping.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != FULL_CNT) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
endmodule

module floatmul_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 4,
  parameter int DATA_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic                    mul_a_valid,
  output logic [DATA_W-1:0]       mul_a_data,
  input  logic                    mul_a_ready,
  output logic                    mul_b_valid,
  output logic [DATA_W-1:0]       mul_b_data,
  input  logic                    mul_b_ready,
  input  logic                    mul_o_valid,
  input  logic [DATA_W-1:0]       mul_o_data,
  output logic                    mul_o_ready,
  output logic                    busy,
  output logic                    err
);
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             a_done_q, a_done_d;
  logic             b_done_q, b_done_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] pick, cand, head_idx;
  logic             any_vld;
  logic             tag_push, tag_pop, tag_empty, tag_full;
  logic             a_hs, b_hs;

  // Scan from farthest to nearest so the requester closest after rr_q wins.
  always_comb begin
    pick    = rr_q;
    cand    = rr_q;
    any_vld = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        pick    = cand;
        any_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    a_done_d    = a_done_q;
    b_done_d    = b_done_q;
    tag_push    = 1'b0;
    mul_a_valid = 1'b0;
    mul_b_valid = 1'b0;
    mul_a_data  = '0;
    mul_b_data  = '0;
    req_ready   = '0;
    a_hs        = 1'b0;
    b_hs        = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_vld && !tag_full) begin
          grant_d  = pick;
          rr_d     = pick;
          tag_push = 1'b1;
          a_done_d = 1'b0;
          b_done_d = 1'b0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mul_a_valid = ~a_done_q;
        mul_b_valid = ~b_done_q;
        mul_a_data  = req_a[int'(grant_q)*DATA_W +: DATA_W];
        mul_b_data  = req_b[int'(grant_q)*DATA_W +: DATA_W];
        a_hs        = mul_a_valid & mul_a_ready;
        b_hs        = mul_b_valid & mul_b_ready;
        if (a_hs) a_done_d = 1'b1;
        if (b_hs) b_done_d = 1'b1;
        // The pair is consumed only once both halves have been accepted.
        if ((a_done_q | a_hs) && (b_done_q | b_hs)) begin
          req_ready[grant_q] = 1'b1;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  floatmul_rr_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_dat (pick),
    .pop      (tag_pop),
    .head_dat (head_idx),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  // Results are owned by the FIFO head; an untagged result is never acknowledged.
  always_comb begin
    rsp_valid   = '0;
    rsp_data    = '0;
    mul_o_ready = 1'b0;
    if (!tag_empty) begin
      rsp_valid[head_idx] = mul_o_valid;
      mul_o_ready         = rsp_ready[head_idx];
      if (mul_o_valid) rsp_data = mul_o_data;
    end
  end

  assign tag_pop = mul_o_valid & mul_o_ready;
  assign err_d   = err_q | (mul_o_valid & tag_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= IDX_W'(N_REQ - 1);
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      err_q    <= err_d;
    end
  end

  assign busy = (state_q != IDLE) | ~tag_empty;
  assign err  = err_q;
endmodule

// File: tb/tb_floatmul_rr_arbiter.sv
// Bench for floatmul_rr_arbiter: bench-side floatmul model plus a grant model and an in-order result scoreboard.
module tb_floatmul_rr_arbiter;
  localparam int N = 4;
  localparam int D = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     rsp_data, mul_a_data, mul_b_data, mul_o_data;
  logic             mul_a_valid, mul_a_ready, mul_b_valid, mul_b_ready;
  logic             mul_o_valid, mul_o_ready, busy, err;

  always #5 clk = ~clk;

  floatmul_rr_arbiter #(.N_REQ(N), .TAG_DEPTH(D), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .mul_a_valid(mul_a_valid), .mul_a_data(mul_a_data), .mul_a_ready(mul_a_ready),
    .mul_b_valid(mul_b_valid), .mul_b_data(mul_b_data), .mul_b_ready(mul_b_ready),
    .mul_o_valid(mul_o_valid), .mul_o_data(mul_o_data), .mul_o_ready(mul_o_ready),
    .busy(busy), .err(err)
  );

  typedef struct { int idx; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { int owner; logic [31:0] data; } exp_t;

  op_t         op_q[$];
  exp_t        sb[$];
  logic [31:0] qa[$], qb[$], rq[$];
  int          grant_log[$], rsp_log[$];

  int checks, failures, cyc, rr_m, a_stall;
  int rr_cnt, rsp_cnt, a_hs_cnt, b_hs_cnt, a_hs_cyc, b_hs_cyc, rr_cyc, rsp_hs_cyc;
  int first_v_cyc, a_vld_cnt, b_vld_cnt, a_unstable, stall, t0, w;
  logic [31:0] a_first, last_rsp_dat;
  logic [N-1:0] rsp_rdy_m;
  logic         b_rdy_m;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating float32 multiply for normal operands; exact for the short mantissas used here.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  function automatic logic [31:0] mkf();
    return {1'b0, 8'($urandom_range(120, 134)), 23'($urandom_range(0, 255) << 15)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int rr);
    for (int k = 1; k <= N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic clear_model();
    op_q.delete(); sb.delete(); qa.delete(); qb.delete(); rq.delete();
    grant_log.delete(); rsp_log.delete();
    rr_m = N - 1; a_stall = 0; b_rdy_m = 1'b1; rsp_rdy_m = '1;
    rr_cnt = 0; rsp_cnt = 0; a_hs_cnt = 0; b_hs_cnt = 0;
    a_hs_cyc = -1; b_hs_cyc = -1; rr_cyc = -1; rsp_hs_cyc = -1;
    first_v_cyc = -1; a_vld_cnt = 0; b_vld_cnt = 0; a_unstable = 0;
    a_first = '0; last_rsp_dat = '0;
  endtask

  task automatic drive();
    req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < op_q.size(); j++)
        if (op_q[j].idx == i && !req_valid[i]) begin
          req_valid[i]     = 1'b1;
          req_a[i*W +: W]  = op_q[j].a;
          req_b[i*W +: W]  = op_q[j].b;
        end
    rsp_ready   = rsp_rdy_m;
    mul_a_ready = (a_stall == 0);
    mul_b_ready = b_rdy_m;
    mul_o_valid = (rq.size() > 0);
    mul_o_data  = (rq.size() > 0) ? rq[0] : '0;
  endtask

  // Sampled mid-cycle: every handshake seen here completes at the next rising edge.
  task automatic observe();
    int eg, oi;
    if (mul_a_valid) begin
      if (first_v_cyc < 0) first_v_cyc = cyc;
      if (a_vld_cnt == 0) a_first = mul_a_data;
      else if (mul_a_data !== a_first) a_unstable++;
      a_vld_cnt++;
    end
    if (mul_b_valid) begin
      if (first_v_cyc < 0) first_v_cyc = cyc;
      b_vld_cnt++;
    end
    if (mul_a_valid && mul_a_ready) begin qa.push_back(mul_a_data); a_hs_cnt++; a_hs_cyc = cyc; end
    if (mul_b_valid && mul_b_ready) begin qb.push_back(mul_b_data); b_hs_cnt++; b_hs_cyc = cyc; end
    if (mul_a_valid && a_stall > 0) a_stall--;

    if (req_ready != '0) begin
      eg = rr_pick(req_valid, rr_m);
      rr_cnt++; rr_cyc = cyc;
      if (eg < 0) chk_eq("grant_spurious", 32'(req_ready), 32'd0);
      else begin
        chk_eq("grant", 32'(req_ready), 32'(1) << eg);
        rr_m = eg;
        grant_log.push_back(eg);
        for (int j = 0; j < op_q.size(); j++)
          if (op_q[j].idx == eg) begin
            sb.push_back('{eg, fmul(op_q[j].a, op_q[j].b)});
            op_q.delete(j);
            break;
          end
      end
    end

    if (mul_o_valid) begin
      if (sb.size() > 0) begin
        chk_eq("rsp_vld", 32'(rsp_valid), 32'(1) << sb[0].owner);
        chk_eq("mul_o_rdy", 32'(mul_o_ready), 32'(rsp_ready[sb[0].owner]));
        if (mul_o_ready) begin
          chk_eq("rsp_dat", rsp_data, sb[0].data);
          oi = -1;
          for (int i = 0; i < N; i++) if (rsp_valid[i]) oi = i;
          rsp_log.push_back(oi);
          last_rsp_dat = rsp_data;
          void'(sb.pop_front());
          void'(rq.pop_front());
          rsp_cnt++; rsp_hs_cyc = cyc;
        end
      end else begin
        chk_eq("stray_rdy", 32'(mul_o_ready), 32'd0);
        chk_eq("stray_vld", 32'(rsp_valid), 32'd0);
        if (mul_o_ready) void'(rq.pop_front());
      end
    end else begin
      chk_eq("rsp_idle", 32'(rsp_valid), 32'd0);
    end

    while (qa.size() > 0 && qb.size() > 0) rq.push_back(fmul(qa.pop_front(), qb.pop_front()));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    drive();
    #1;
    observe();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n, input string tag);
    for (int k = 0; k < 300 && rsp_cnt < n; k++) tick();
    chk_eq(tag, rsp_cnt, n);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    clear_model();
    rst_n = 1'b1;
    drive();
    #1 rst_n = 1'b0;
    #1;
    chk_eq("rst_req_ready", 32'(req_ready), 0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    chk_eq("rst_mul_a_valid", 32'(mul_a_valid), 0);
    chk_eq("rst_mul_b_valid", 32'(mul_b_valid), 0);
    chk_eq("rst_mul_o_ready", 32'(mul_o_ready), 0);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_err", 32'(err), 0);

    // Single operation: 1.5 * 2.0 from requester 2.
    do_reset();
    op_q.push_back('{2, 32'h3FC00000, 32'h40000000});
    t0 = cyc + 1;
    drain(1, "single_done");
    repeat (2) tick();
    chk_eq("single_latency", first_v_cyc - t0, 1);
    chk_eq("single_a_hs", a_hs_cnt, 1);
    chk_eq("single_b_hs", b_hs_cnt, 1);
    chk_eq("single_req_ready_pulses", rr_cnt, 1);
    chk_eq("single_owner", (rsp_log.size() > 0) ? rsp_log[0] : -1, 2);
    chk_eq("single_data", last_rsp_dat, 32'h40400000);
    chk_eq("single_busy_idle", 32'(busy), 0);

    // Fairness: all four requesters hold two pairs each.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) op_q.push_back('{i, mkf(), mkf()});
    drain(8, "fair_done");
    for (int k = 0; k < 8; k++) begin
      chk_eq($sformatf("fair_grant%0d", k), (k < grant_log.size()) ? grant_log[k] : -1, k % N);
      chk_eq($sformatf("fair_route%0d", k), (k < rsp_log.size()) ? rsp_log[k] : -1, k % N);
    end

    // Split handshake: a stalled for three ISSUE cycles, b ready throughout.
    do_reset();
    a_stall = 3;
    op_q.push_back('{1, 32'h3F800000, 32'h40400000});
    for (int k = 0; k < 30 && rr_cnt < 1; k++) tick();
    chk_eq("split_grant_done", rr_cnt, 1);
    chk_eq("split_b_hs", b_hs_cnt, 1);
    chk_eq("split_b_vld_cycles", b_vld_cnt, 1);
    chk_eq("split_b_first_cycle", b_hs_cyc - first_v_cyc, 0);
    chk_eq("split_a_hs_cycle", a_hs_cyc - first_v_cyc, 3);
    chk_eq("split_req_ready_on_a", rr_cyc - a_hs_cyc, 0);
    chk_eq("split_a_vld_cycles", a_vld_cnt, 4);
    chk_eq("split_a_stable", a_unstable, 0);
    chk_eq("split_a_data", a_first, 32'h3F800000);
    drain(1, "split_rsp_done");

    // Tag FIFO full: results held back, fifth grant only after one return.
    do_reset();
    rsp_rdy_m = '0;
    for (int i = 0; i < N; i++) op_q.push_back('{i, mkf(), mkf()});
    op_q.push_back('{0, mkf(), mkf()});
    repeat (30) tick();
    chk_eq("full_grants", rr_cnt, D);
    chk_eq("full_busy", 32'(busy), 1);
    rsp_rdy_m = 4'b0001;
    for (int k = 0; k < 10 && rsp_cnt < 1; k++) tick();
    rsp_rdy_m = '0;
    chk_eq("full_one_rsp", rsp_cnt, 1);
    w = rsp_hs_cyc;
    for (int k = 0; k < 10 && rr_cnt < D + 1; k++) tick();
    chk_eq("full_fifth_grant", rr_cnt, D + 1);
    chk_eq("full_fifth_delay", rr_cyc - w, 2);
    chk_eq("full_fifth_owner", (grant_log.size() > D) ? grant_log[D] : -1, 0);
    rsp_rdy_m = '1;
    drain(D + 1, "full_drain");

    // Head-of-line: result for requester 1 blocked, result for 3 waits behind it.
    do_reset();
    rsp_rdy_m = 4'b1000;
    op_q.push_back('{1, mkf(), mkf()});
    op_q.push_back('{3, mkf(), mkf()});
    for (int k = 0; k < 30 && rq.size() < 2; k++) tick();
    chk_eq("hol_queued", rq.size(), 2);
    stall = 0;
    repeat (5) begin
      tick();
      if (mul_o_valid && !mul_o_ready) stall++;
    end
    chk_eq("hol_stall_cycles", stall, 5);
    chk_eq("hol_none_early", rsp_cnt, 0);
    rsp_rdy_m = '1;
    drain(2, "hol_drain");
    chk_eq("hol_first", (rsp_log.size() > 0) ? rsp_log[0] : -1, 1);
    chk_eq("hol_second", (rsp_log.size() > 1) ? rsp_log[1] : -1, 3);

    // Asynchronous reset in ISSUE with two tags outstanding.
    do_reset();
    rsp_rdy_m = '0;
    op_q.push_back('{0, mkf(), mkf()});
    op_q.push_back('{1, mkf(), mkf()});
    for (int k = 0; k < 20 && rr_cnt < 1; k++) tick();
    a_stall = 100;
    repeat (2) tick();
    chk_eq("ar_pre_issue", 32'(mul_a_valid), 1);
    chk_eq("ar_pre_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("ar_req_ready", 32'(req_ready), 0);
    chk_eq("ar_rsp_valid", 32'(rsp_valid), 0);
    chk_eq("ar_rsp_data", rsp_data, 0);
    chk_eq("ar_mul_a_valid", 32'(mul_a_valid), 0);
    chk_eq("ar_mul_b_valid", 32'(mul_b_valid), 0);
    chk_eq("ar_mul_a_data", mul_a_data, 0);
    chk_eq("ar_mul_o_ready", 32'(mul_o_ready), 0);
    chk_eq("ar_busy", 32'(busy), 0);
    do_reset();
    for (int i = N - 1; i >= 0; i--) op_q.push_back('{i, mkf(), mkf()});
    drain(N, "ar_drain");
    chk_eq("ar_first_winner", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk_eq("ar_err_clear", 32'(err), 0);
    rq.push_back(32'hDEADBEEF);
    tick();
    rq.delete();
    tick();
    chk_eq("stray_err_set", 32'(err), 1);
    repeat (3) tick();
    chk_eq("stray_err_sticky", 32'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
